// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//
// Shares one pipelined floating-point adder between two requesters.
// A round-robin grant picks at most one operand pair per cycle. The pair is
// registered into the adder. The owner id then rides a tag pipeline whose
// depth matches the adder latency, so each packed result is returned to the
// requester that issued it.
//
// Parameters
//   W    unpacked operand width (sign, 8-bit exponent, 28-bit mantissa)
//   RW   packed result width (IEEE-754 single)
//   LAT  adder latency from add_valid_o to add_res_i, 1..8
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   hold                       blocks new grants; in-flight ops still retire
//   reqN_valid/ready/a/b       requester N operand handshake (ready is
//                              combinational)
//   add_valid_o/add_a_o/add_b_o registered operand pair into the adder
//   add_res_i                  adder result, valid LAT cycles after
//                              add_valid_o
//   resN_valid/resN_data       one-cycle result pulse for requester N; the
//                              data is held between pulses
//   busy                       an issue or any tag stage is still in flight
module fp_add_arbiter #(
   parameter int W   = 37,
   parameter int RW  = 32,
   parameter int LAT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   output logic          add_valid_o,
   output logic [W-1:0]  add_a_o,
   output logic [W-1:0]  add_b_o,
   input  logic [RW-1:0] add_res_i,
   output logic          res0_valid,
   output logic [RW-1:0] res0_data,
   output logic          res1_valid,
   output logic [RW-1:0] res1_data,
   output logic          busy
);

   // prio = 0 favours requester 0 when both are valid
   logic           prio;
   logic           gnt0;
   logic           gnt1;
   logic           contested;

   // Owner id of the operation currently sitting in the issue register
   logic           issue_id_p0;

   // Tag pipeline: stage LAT-1 lines up with add_res_i being valid
   logic [LAT-1:0] tag_vld_p;
   logic [LAT-1:0] tag_id_p;

   assign contested = req0_valid && req1_valid && !hold;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!hold) begin
         if (req0_valid && req1_valid) begin
            gnt0 = !prio;
            gnt1 = prio;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // ---- stage p0: issue register into the adder ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_valid_o <= 1'b0;
         add_a_o     <= '0;
         add_b_o     <= '0;
         issue_id_p0 <= 1'b0;
         prio        <= 1'b0;
      end else begin
         add_valid_o <= gnt0 || gnt1;
         issue_id_p0 <= gnt1;
         if (gnt0 || gnt1) begin
            add_a_o <= gnt1 ? req1_a : req0_a;
            add_b_o <= gnt1 ? req1_b : req0_b;
         end
         // Handing priority to the loser makes contested grants alternate
         if (contested) begin
            prio <= ~prio;
         end
      end
   end

   // ---- stages p1..pLAT: tag pipeline, advances every cycle ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_p <= '0;
         tag_id_p  <= '0;
      end else begin
         tag_vld_p[0] <= add_valid_o;
         tag_id_p[0]  <= issue_id_p0;
         for (int i = 1; i < LAT; i++) begin
            tag_vld_p[i] <= tag_vld_p[i-1];
            tag_id_p[i]  <= tag_id_p[i-1];
         end
      end
   end

   // ---- retire stage: route the adder result to its owner ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res0_data  <= '0;
         res1_data  <= '0;
      end else begin
         res0_valid <= tag_vld_p[LAT-1] && !tag_id_p[LAT-1];
         res1_valid <= tag_vld_p[LAT-1] &&  tag_id_p[LAT-1];
         if (tag_vld_p[LAT-1]) begin
            if (tag_id_p[LAT-1]) begin
               res1_data <= add_res_i;
            end else begin
               res0_data <= add_res_i;
            end
         end
      end
   end

   assign busy = add_valid_o || (|tag_vld_p);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: three builds (LAT = 1, 3, 8) share one stimulus
// stream. Each build has its own adder model (low 32 bits of a+b) and its
// own scoreboard, which a negedge monitor drains.
module tb_fp_add_arbiter;

   localparam int W  = 37;
   localparam int RW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hold;
   logic          v0, v1;
   logic [W-1:0]  a0, b0, a1, b1;
   logic          done = 1'b0;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            ecount = 0;

   // Reference grant model: priority pointer handed to the loser of a
   // contested grant
   logic          rr;
   logic          exp_g0, exp_g1;

   always #5 clk = ~clk;

   assign exp_g0 = !hold && v0 && (!v1 || (rr == 1'b0));
   assign exp_g1 = !hold && v1 && (!v0 || (rr == 1'b1));

   always @(posedge clk) ecount <= ecount + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 rr <= 1'b0;
      else if (!hold && v0 && v1) rr <= ~rr;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int           id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           e;     // index of the handshake edge
   } op_t;

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int L = (gi == 0) ? 1 : (gi == 1) ? 3 : 8;

      logic          r0, r1, av, rv0, rv1, bz;
      logic [W-1:0]  aa, ab;
      logic [RW-1:0] ares, d0, d1;
      logic [RW-1:0] pipe [L];
      logic [RW-1:0] last0, last1;
      op_t           sb[$];

      fp_add_arbiter #(.W(W), .RW(RW), .LAT(L)) dut (
         .clk(clk), .rst_n(rst_n), .hold(hold),
         .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
         .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
         .add_valid_o(av), .add_a_o(aa), .add_b_o(ab), .add_res_i(ares),
         .res0_valid(rv0), .res0_data(d0), .res1_valid(rv1), .res1_data(d1),
         .busy(bz)
      );

      // Adder model: L-cycle delay of the low 32 bits of a+b
      always @(posedge clk) begin
         logic [W-1:0] s;
         s = aa + ab;
         pipe[0] <= s[RW-1:0];
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign ares = pipe[L-1];

      // Expected responses are queued at the handshake edge
      always @(posedge clk) begin
         if (rst_n) begin
            if (exp_g0) sb.push_back('{0, a0, b0, ecount + 1});
            if (exp_g1) sb.push_back('{1, a1, b1, ecount + 1});
         end
      end

      always @(negedge rst_n) begin
         sb.delete();
         #1;
         chk($sformatf("L%0d async rst add_valid", L), av, 0);
         chk($sformatf("L%0d async rst busy", L), bz, 0);
         chk($sformatf("L%0d async rst res valids", L), {rv0, rv1}, 0);
      end

      always @(negedge clk) begin
         int  now;
         logic exp_av, exp_bz, exp_res;
         logic [W-1:0] s;
         now = ecount;
         if (!rst_n) begin
            sb.delete();
            last0 = '0;
            last1 = '0;
            chk($sformatf("L%0d rst add_valid", L), av, 0);
            chk($sformatf("L%0d rst add_a/b", L), {aa, ab}, 0);
            chk($sformatf("L%0d rst res valids", L), {rv0, rv1}, 0);
            chk($sformatf("L%0d rst res data", L), {d0, d1}, 0);
            chk($sformatf("L%0d rst busy", L), bz, 0);
         end else begin
            chk($sformatf("L%0d req0_ready", L), r0, exp_g0);
            chk($sformatf("L%0d req1_ready", L), r1, exp_g1);
            exp_av  = (sb.size() > 0) && (sb[$].e == now);
            exp_bz  = (sb.size() > 0) && (sb[$].e + L >= now);
            exp_res = (sb.size() > 0) && (sb[0].e + L + 1 == now);
            chk($sformatf("L%0d add_valid_o", L), av, exp_av);
            if (exp_av) chk($sformatf("L%0d add operands", L), {aa, ab}, {sb[$].a, sb[$].b});
            chk($sformatf("L%0d busy", L), bz, exp_bz);
            chk($sformatf("L%0d res0_valid", L), rv0, exp_res && (sb[0].id == 0));
            chk($sformatf("L%0d res1_valid", L), rv1, exp_res && (sb[0].id == 1));
            if (exp_res) begin
               s = sb[0].a + sb[0].b;
               if (sb[0].id == 0) last0 = s[RW-1:0];
               else               last1 = s[RW-1:0];
               void'(sb.pop_front());
            end
            chk($sformatf("L%0d res0_data", L), d0, last0);
            chk($sformatf("L%0d res1_data", L), d1, last1);
         end
      end

      always @(posedge done) chk($sformatf("L%0d ops outstanding at end", L), sb.size(), 0);
   end

   function automatic logic [W-1:0] rnd();
      return W'({$urandom(), $urandom()});
   endfunction

   // One cycle of requester behaviour: a requester that is not granted keeps
   // its operands; otherwise it draws a new request with probability p.
   task automatic step(input int p0, input int p1, input int ph);
      logic took0, took1;
      took0 = exp_g0;
      took1 = exp_g1;
      @(posedge clk);
      #2;
      if (took0 || !v0) begin
         v0 = ($urandom_range(99) < p0);
         a0 = rnd();
         b0 = rnd();
      end
      if (took1 || !v1) begin
         v1 = ($urandom_range(99) < p1);
         a1 = rnd();
         b1 = rnd();
      end
      hold = ($urandom_range(99) < ph);
   endtask

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // single op from requester 0: 5 + 3
      v0 = 1'b1; a0 = 37'h5; b0 = 37'h3;
      repeat (12) step(0, 0, 0);

      // both requesters contending
      repeat (4) step(100, 100, 0);
      repeat (12) step(0, 0, 0);

      // requester 1 alone, back to back
      repeat (6) step(0, 100, 0);
      repeat (12) step(0, 0, 0);

      // hold while both are valid, then release
      repeat (3) step(100, 100, 100);
      repeat (3) step(100, 100, 0);
      repeat (12) step(0, 0, 0);

      // reset two cycles after an issue
      step(100, 0, 0);
      step(0, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) step(100, 100, 0);

      // random mix with occasional hold
      repeat (80) step(60, 60, 15);
      repeat (16) step(0, 0, 0);

      done = 1'b1;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
